// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//   - grant FSM state encodings
//   - FFT window decode constants, used by decoders and benches (the arbiter
//     itself never looks at the address)
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   localparam logic [7:0] FFT_WIN_MASK = 8'hF8;
   localparam logic [7:0] FFT_WIN_BASE = 8'hF8;

endpackage

// File: rtl/arb_bus_mux.sv
// 2:1 bus mux in front of the intercept stage.
// Ports:
//   gnt0, gnt1            registered one-hot grant (both 0 = idle)
//   req*, write*, adr*, wdata*   master request fields
//   bus_adr, bus_wdata    granted master's address / write data, 0 when idle
//   bus_write             granted master's WRITE qualified by its REQ
module arb_bus_mux #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          gnt0,
   input  logic          gnt1,
   input  logic          req0,
   input  logic          req1,
   input  logic          write0,
   input  logic          write1,
   input  logic [AW-1:0] adr0,
   input  logic [AW-1:0] adr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [AW-1:0] bus_adr,
   output logic [DW-1:0] bus_wdata,
   output logic          bus_write
);

   always_comb begin
      bus_adr   = '0;
      bus_wdata = '0;
      bus_write = 1'b0;
      if (gnt0) begin
         bus_adr   = adr0;
         bus_wdata = wdata0;
         bus_write = write0 & req0;
      end else if (gnt1) begin
         bus_adr   = adr1;
         bus_wdata = wdata1;
         bus_write = write1 & req1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared address/write-data bus feeding the
// memory/FFT intercept stage. M0 (CPU) wins the first tie; afterwards ties
// go round-robin. Locked bursts are capped at MAX_BURST beats.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   REQn, LOCKn, WRITEn, ADRn, WDATAn   master n request
//   ACKn                  master n transfer completes this cycle
//   RDATAn                read data to master n (0 unless acked)
//   GNTn                  registered grant
//   BUS_ADR/WDATA/WRITE   to intercept stage
//   BUS_RDATA             read data from intercept stage
//
// state | meaning
// IDLE  | nobody owns the bus, bus outputs driven to 0
// OWN0  | M0 granted, its REQ completes each cycle
// OWN1  | M1 granted, its REQ completes each cycle
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          REQ0,
   input  logic          REQ1,
   input  logic          LOCK0,
   input  logic          LOCK1,
   input  logic          WRITE0,
   input  logic          WRITE1,
   input  logic [AW-1:0] ADR0,
   input  logic [AW-1:0] ADR1,
   input  logic [DW-1:0] WDATA0,
   input  logic [DW-1:0] WDATA1,
   output logic          ACK0,
   output logic          ACK1,
   output logic [DW-1:0] RDATA0,
   output logic [DW-1:0] RDATA1,
   output logic          GNT0,
   output logic          GNT1,
   output logic [AW-1:0] BUS_ADR,
   output logic [DW-1:0] BUS_WDATA,
   output logic          BUS_WRITE,
   input  logic [DW-1:0] BUS_RDATA
);

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   logic [1:0] state, state_nxt;
   logic [7:0] burst_cnt, burst_cnt_nxt;
   logic       last, last_nxt;   // index of the master that last finished a burst

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         last      <= 1'b1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         last      <= last_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      last_nxt      = last;
      case (state)
         ST_OWN0: begin
            if (!REQ0) begin
               state_nxt     = REQ1 ? ST_OWN1 : ST_IDLE;
               burst_cnt_nxt = '0;
            end else if (LOCK0 && burst_cnt < BURST_LAST) begin
               burst_cnt_nxt = burst_cnt + 8'd1;
            end else begin
               // burst over: hand over if M1 waits, else start a fresh burst
               last_nxt      = 1'b0;
               burst_cnt_nxt = '0;
               state_nxt     = REQ1 ? ST_OWN1 : ST_OWN0;
            end
         end
         ST_OWN1: begin
            if (!REQ1) begin
               state_nxt     = REQ0 ? ST_OWN0 : ST_IDLE;
               burst_cnt_nxt = '0;
            end else if (LOCK1 && burst_cnt < BURST_LAST) begin
               burst_cnt_nxt = burst_cnt + 8'd1;
            end else begin
               last_nxt      = 1'b1;
               burst_cnt_nxt = '0;
               state_nxt     = REQ0 ? ST_OWN0 : ST_OWN1;
            end
         end
         default: begin
            burst_cnt_nxt = '0;
            if (REQ0 && REQ1)
               state_nxt = last ? ST_OWN0 : ST_OWN1;
            else if (REQ0)
               state_nxt = ST_OWN0;
            else if (REQ1)
               state_nxt = ST_OWN1;
            else
               state_nxt = ST_IDLE;
         end
      endcase
   end

   assign GNT0   = (state == ST_OWN0);
   assign GNT1   = (state == ST_OWN1);
   assign ACK0   = GNT0 & REQ0;
   assign ACK1   = GNT1 & REQ1;
   assign RDATA0 = ACK0 ? BUS_RDATA : '0;
   assign RDATA1 = ACK1 ? BUS_RDATA : '0;

   arb_bus_mux #(.AW(AW), .DW(DW)) u_bus_mux (
      .gnt0      (GNT0),
      .gnt1      (GNT1),
      .req0      (REQ0),
      .req1      (REQ1),
      .write0    (WRITE0),
      .write1    (WRITE1),
      .adr0      (ADR0),
      .adr1      (ADR1),
      .wdata0    (WDATA0),
      .wdata1    (WDATA1),
      .bus_adr   (BUS_ADR),
      .bus_wdata (BUS_WDATA),
      .bus_write (BUS_WRITE)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   logic       CLK, RESET;
   logic       REQ0, REQ1, LOCK0, LOCK1, WRITE0, WRITE1;
   logic [7:0] ADR0, ADR1, WDATA0, WDATA1;
   logic       ACK0, ACK1, GNT0, GNT1, BUS_WRITE;
   logic [7:0] RDATA0, RDATA1, BUS_ADR, BUS_WDATA, BUS_RDATA;

   int errors = 0;
   int checks = 0;

   mem_bus_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
      .WRITE0(WRITE0), .WRITE1(WRITE1),
      .ADR0(ADR0), .ADR1(ADR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
      .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
      .GNT0(GNT0), .GNT1(GNT1),
      .BUS_ADR(BUS_ADR), .BUS_WDATA(BUS_WDATA), .BUS_WRITE(BUS_WRITE),
      .BUS_RDATA(BUS_RDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      REQ0 = 0; REQ1 = 0; LOCK0 = 0; LOCK1 = 0; WRITE0 = 0; WRITE1 = 0;
      ADR0 = 0; ADR1 = 0; WDATA0 = 0; WDATA1 = 0; BUS_RDATA = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RESET = 1;
      step();
      RESET = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({GNT0, GNT1, ACK0, ACK1, BUS_WRITE} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got gnt/ack/wr=%b required 00000", {GNT0, GNT1, ACK0, ACK1, BUS_WRITE});
      end
      checks++;
      if ({BUS_ADR, BUS_WDATA, RDATA0, RDATA1} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", {BUS_ADR, BUS_WDATA, RDATA0, RDATA1});
      end
   endtask

   task automatic test_single_write();
      do_reset();
      REQ0 = 1; ADR0 = 8'h10; WRITE0 = 1; WDATA0 = 8'h5A;
      #1;
      checks++;
      if (GNT0 !== 1'b0 || ACK0 !== 1'b0) begin
         errors++;
         $display("FAIL write_latency: got gnt0=%b ack0=%b required 0 0", GNT0, ACK0);
      end
      step();
      checks++;
      if (GNT0 !== 1'b1 || ACK0 !== 1'b1 || BUS_WRITE !== 1'b1) begin
         errors++;
         $display("FAIL write_grant: got gnt0=%b ack0=%b wr=%b required 1 1 1", GNT0, ACK0, BUS_WRITE);
      end
      checks++;
      if (BUS_ADR !== 8'h10 || BUS_WDATA !== 8'h5A) begin
         errors++;
         $display("FAIL write_bus: got adr=%h wdata=%h required 10 5a", BUS_ADR, BUS_WDATA);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp0, exp1;
      exp0 = 4'b0101;   // bit i = beat i
      exp1 = 4'b1010;
      do_reset();
      REQ0 = 1; REQ1 = 1; ADR0 = 8'h01; ADR1 = 8'h02;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (ACK0 !== exp0[i] || ACK1 !== exp1[i]) begin
            errors++;
            $display("FAIL rr_beat%0d: got ack0=%b ack1=%b required %b %b", i, ACK0, ACK1, exp0[i], exp1[i]);
         end
      end
   endtask

   task automatic test_burst_cap();
      logic [5:0] exp0, exp1;
      exp0 = 6'b101111;
      exp1 = 6'b010000;
      do_reset();
      REQ0 = 1; LOCK0 = 1; REQ1 = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ACK0 !== exp0[i] || ACK1 !== exp1[i]) begin
            errors++;
            $display("FAIL burst_beat%0d: got ack0=%b ack1=%b required %b %b", i, ACK0, ACK1, exp0[i], exp1[i]);
         end
      end
   endtask

   task automatic test_lock_alone();
      // cap reached with nobody waiting: M0 keeps the bus in a fresh burst
      do_reset();
      REQ0 = 1; LOCK0 = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ACK0 !== 1'b1 || GNT1 !== 1'b0) begin
            errors++;
            $display("FAIL lock_alone%0d: got ack0=%b gnt1=%b required 1 0", i, ACK0, GNT1);
         end
      end
   endtask

   task automatic test_fft_read();
      do_reset();
      REQ1 = 1; WRITE1 = 0; ADR1 = FFT_WIN_BASE; BUS_RDATA = 8'hC3;
      step();
      checks++;
      if (ACK1 !== 1'b1 || RDATA1 !== 8'hC3 || BUS_WRITE !== 1'b0 || RDATA0 !== 8'h00) begin
         errors++;
         $display("FAIL fft_read: got ack1=%b rd1=%h wr=%b rd0=%h required 1 c3 0 00", ACK1, RDATA1, BUS_WRITE, RDATA0);
      end
      checks++;
      if (BUS_ADR !== 8'hF8) begin
         errors++;
         $display("FAIL fft_adr: got %h required f8", BUS_ADR);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      REQ1 = 1; LOCK1 = 1; WRITE1 = 1; ADR1 = 8'h22;
      step();
      checks++;
      if (ACK1 !== 1'b1) begin
         errors++;
         $display("FAIL rst_beat1: got ack1=%b required 1", ACK1);
      end
      step();
      checks++;
      if (ACK1 !== 1'b1 || BUS_WRITE !== 1'b1) begin
         errors++;
         $display("FAIL rst_beat2: got ack1=%b wr=%b required 1 1", ACK1, BUS_WRITE);
      end
      RESET = 1;
      step();
      checks++;
      if (GNT1 !== 1'b0 || ACK1 !== 1'b0 || BUS_WRITE !== 1'b0) begin
         errors++;
         $display("FAIL rst_abort: got gnt1=%b ack1=%b wr=%b required 0 0 0", GNT1, ACK1, BUS_WRITE);
      end
      RESET = 0; REQ0 = 1;
      step();
      checks++;
      if (GNT0 !== 1'b1 || ACK0 !== 1'b1 || GNT1 !== 1'b0) begin
         errors++;
         $display("FAIL rst_tie: got gnt0=%b ack0=%b gnt1=%b required 1 1 0", GNT0, ACK0, GNT1);
      end
   endtask

   task automatic test_release_idle();
      do_reset();
      REQ0 = 1; ADR0 = 8'h33;
      step();
      REQ0 = 0;
      #1;
      checks++;
      if (ACK0 !== 1'b0 || GNT0 !== 1'b1) begin
         errors++;
         $display("FAIL release_cycle: got ack0=%b gnt0=%b required 0 1", ACK0, GNT0);
      end
      step();
      checks++;
      if (GNT0 !== 1'b0 || GNT1 !== 1'b0 || BUS_ADR !== 8'h00) begin
         errors++;
         $display("FAIL release_idle: got gnt0=%b gnt1=%b adr=%h required 0 0 00", GNT0, GNT1, BUS_ADR);
      end
   endtask

   initial begin
      RESET = 1;
      clear_inputs();
      test_reset();
      test_single_write();
      test_round_robin();
      test_burst_cap();
      test_lock_alone();
      test_fft_read();
      test_reset_mid_burst();
      test_release_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
